// File: rtl/regfile_mp_if.sv
// regfile_mp_if: port bundle for the multi-port register file.
//   master: drives write ports, read enables/addresses and pend_set;
//           receives rdata, rbusy and init_done.
//   slave : the register file side of the same bundle.
// raddr/rdata are packed with port k at [k*ADDR_W +: ADDR_W] and [k*DATA_W +: DATA_W].
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic [NUM_RD-1:0]        rbusy;
  logic                     init_done;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, pend_set, pend_addr,
    input  rdata, rbusy, init_done
  );
  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, pend_set, pend_addr,
    output rdata, rbusy, init_done
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the MIPS core.
//   NUM_RD combinational read ports with write-to-read bypass, two write ports
//   (port 1 wins on address collision), a per-register pending-write scoreboard
//   for hazard detection, and a post-reset sequencer that clears every register.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous reset, active-high; restarts the init sequence
//   bus  - regfile_mp_if.slave: write ports, read ports, pend_set, rbusy, init_done

// One read port: range/zero filtering, bypass from the write ports, busy flag.
module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                             run_ok,
  input  logic                             re,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic                             wq0,
  input  logic [ADDR_W-1:0]                waddr0,
  input  logic [DATA_W-1:0]                wdata0,
  input  logic                             wq1,
  input  logic [ADDR_W-1:0]                waddr1,
  input  logic [DATA_W-1:0]                wdata1,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem,
  input  logic [NUM_REGS-1:0]              pend,
  output logic [DATA_W-1:0]                rdata,
  output logic                             rbusy
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] arr;
  logic              pnd, hit0, hit1, valid;

  always_comb begin
    arr = '0;
    pnd = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_W'(i)) begin
        arr = mem[i];
        pnd = pend[i];
      end
    end
    hit1  = wq1 && (waddr1 == raddr);
    hit0  = wq0 && (waddr0 == raddr);
    valid = run_ok && re && ({1'b0, raddr} < NREGS) && !(ZERO_REG != 0 && raddr == '0);
    rdata = '0;
    rbusy = 1'b0;
    if (valid) begin
      rdata = hit1 ? wdata1 : (hit0 ? wdata0 : arr);
      // a write landing this cycle resolves the hazard: data is bypassed
      rbusy = pnd && !hit1 && !hit0;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam logic [0:0]        ST_INIT = 1'b0;
  localparam logic [0:0]        ST_RUN  = 1'b1;
  localparam logic [ADDR_W:0]   NREGS   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_REGS-1);

  logic [0:0]                      state;
  logic [ADDR_W-1:0]               init_cnt;
  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0]             pend;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_q;
  logic [NUM_RD-1:0]               busy_q;
  logic                            run_ok, wq0, wq1, pq;

  assign bus.init_done = (state == ST_RUN);
  // rst gates outputs and writes in the same cycle it is asserted
  assign run_ok = (state == ST_RUN) && !rst;

  // qualified writes: in range and not the hardwired zero register
  assign wq0 = run_ok && bus.we0 && ({1'b0, bus.waddr0} < NREGS) &&
               !(ZERO_REG != 0 && bus.waddr0 == '0);
  assign wq1 = run_ok && bus.we1 && ({1'b0, bus.waddr1} < NREGS) &&
               !(ZERO_REG != 0 && bus.waddr1 == '0);
  assign pq  = run_ok && bus.pend_set && ({1'b0, bus.pend_addr} < NREGS) &&
               !(ZERO_REG != 0 && bus.pend_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst && state == ST_INIT && init_cnt == ADDR_W'(i)) mem[i] <= '0;
      else if (wq1 && bus.waddr1 == ADDR_W'(i))               mem[i] <= bus.wdata1;
      else if (wq0 && bus.waddr0 == ADDR_W'(i))               mem[i] <= bus.wdata0;
    end
  end

  // set beats clear: a new producer issued on the edge the old one retires
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pq && bus.pend_addr == ADDR_W'(i))
          pend[i] <= 1'b1;
        else if ((wq0 && bus.waddr0 == ADDR_W'(i)) || (wq1 && bus.waddr1 == ADDR_W'(i)))
          pend[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .run_ok (run_ok),
      .re     (bus.re[k]),
      .raddr  (bus.raddr[k*ADDR_W +: ADDR_W]),
      .wq0    (wq0),
      .waddr0 (bus.waddr0),
      .wdata0 (bus.wdata0),
      .wq1    (wq1),
      .waddr1 (bus.waddr1),
      .wdata1 (bus.wdata1),
      .mem    (mem),
      .pend   (pend),
      .rdata  (rd_q[k]),
      .rbusy  (busy_q[k])
    );
  end

  assign bus.rdata = rd_q;
  assign bus.rbusy = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two register files from the same stimulus
// (A: 32 regs / 2 read ports, B: 16 regs / 3 read ports) and checks every
// output each cycle against an array-based model of the register rules.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we0, we1, pend_set;
  logic [4:0]  waddr0, waddr1, pend_addr;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  re;
  logic [14:0] raddr;

  int total = 0;
  int bad   = 0;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) ifb ();

  assign ifa.we0 = we0;  assign ifa.waddr0 = waddr0;  assign ifa.wdata0 = wdata0;
  assign ifa.we1 = we1;  assign ifa.waddr1 = waddr1;  assign ifa.wdata1 = wdata1;
  assign ifa.re = re[1:0];  assign ifa.raddr = raddr[9:0];
  assign ifa.pend_set = pend_set;  assign ifa.pend_addr = pend_addr;
  assign ifb.we0 = we0;  assign ifb.waddr0 = waddr0;  assign ifb.wdata0 = wdata0;
  assign ifb.we1 = we1;  assign ifb.waddr1 = waddr1;  assign ifb.wdata1 = wdata1;
  assign ifb.re = re;  assign ifb.raddr = raddr;
  assign ifb.pend_set = pend_set;  assign ifb.pend_addr = pend_addr;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1))
    ua (.clk(clk), .rst(rst), .bus(ifa));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .NUM_RD(3), .ZERO_REG(1))
    ub (.clk(clk), .rst(rst), .bus(ifb));

  // model: index 0 = instance A, 1 = instance B
  logic [31:0] mm [2][32];
  bit          pp [2][32];
  int          since = 0;   // edges with rst low since the last reset edge

  function automatic int nregs(input int w);
    return (w != 0) ? 16 : 32;
  endfunction

  function automatic bit wok(input int n, input logic we, input logic [4:0] a);
    return we && (int'(a) < n) && (a != 5'd0);
  endfunction

  function automatic void expect_rd(input int w, input int a, input bit en,
                                    output logic [31:0] d, output bit b);
    int n;
    n = nregs(w);
    d = '0;
    b = 1'b0;
    if ((since >= n) && !rst && en && a != 0 && a < n) begin
      if (wok(n, we1, waddr1) && int'(waddr1) == a)      d = wdata1;
      else if (wok(n, we0, waddr0) && int'(waddr0) == a) d = wdata0;
      else begin
        d = mm[w][a];
        b = pp[w][a];
      end
    end
  endfunction

  function automatic void update();
    int n;
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 32; i++) begin
          mm[w][i] = '0;
          pp[w][i] = 1'b0;
        end
      since = 0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        n = nregs(w);
        if (since >= n) begin
          if (wok(n, we0, waddr0)) begin mm[w][waddr0] = wdata0; pp[w][waddr0] = 1'b0; end
          if (wok(n, we1, waddr1)) begin mm[w][waddr1] = wdata1; pp[w][waddr1] = 1'b0; end
          if (pend_set && pend_addr != 5'd0 && int'(pend_addr) < n) pp[w][pend_addr] = 1'b1;
        end
      end
      since++;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs are already applied (at negedge); check, clock, advance model
  task automatic cyc();
    logic [31:0] d;
    bit          b;
    #1;
    chk("done_a", 32'(ifa.init_done), 32'(since >= 32));
    chk("done_b", 32'(ifb.init_done), 32'(since >= 16));
    for (int k = 0; k < 2; k++) begin
      expect_rd(0, int'(raddr[k*5 +: 5]), re[k], d, b);
      chk($sformatf("rdata_a%0d", k), ifa.rdata[k*32 +: 32], d);
      chk($sformatf("rbusy_a%0d", k), 32'(ifa.rbusy[k]), 32'(b));
    end
    for (int k = 0; k < 3; k++) begin
      expect_rd(1, int'(raddr[k*5 +: 5]), re[k], d, b);
      chk($sformatf("rdata_b%0d", k), ifb.rdata[k*32 +: 32], d);
      chk($sformatf("rbusy_b%0d", k), 32'(ifb.rbusy[k]), 32'(b));
    end
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic setrd(input int k, input int a);
    raddr[k*5 +: 5] = 5'(a);
    re[k] = 1'b1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; pend_set = 0;
  endtask

  initial begin
    rst = 1; idle();
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; pend_addr = 0;
    re = 0; raddr = 0;
    @(negedge clk);
    cyc();
    rst = 0;

    // 1: init length, writes ignored during init, r1..r31 read 0
    re = 3'b111;
    #1 chk("t1_done_lo", 32'(ifa.init_done), 32'd0);
    for (int i = 0; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = 32'hDEAD0000 | 32'(i);
      raddr = {5'(i), 5'(i), 5'(i)};
      cyc();
    end
    idle();
    #1 chk("t1_done_hi", 32'(ifa.init_done), 32'd1);
    for (int i = 1; i < 32; i++) begin
      raddr = {5'(i), 5'(32 - i), 5'(i)};
      cyc();
    end

    // 2: bypass then array
    re = 0; we0 = 1; waddr0 = 5; wdata0 = 32'h1234; setrd(0, 5);
    #1 chk("t2_bypass", ifa.rdata[31:0], 32'h1234);
    cyc();
    idle();
    #1 chk("t2_array", ifa.rdata[31:0], 32'h1234);
    cyc();

    // 3: port 1 priority, r0 hardwired
    we0 = 1; waddr0 = 7; wdata0 = 32'hAAAA; we1 = 1; waddr1 = 7; wdata1 = 32'h5555;
    cyc();
    idle(); setrd(0, 7);
    #1 chk("t3_prio", ifa.rdata[31:0], 32'h5555);
    cyc();
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; setrd(1, 0);
    cyc();
    idle();
    #1 chk("t3_r0", ifa.rdata[63:32], 32'h0);
    cyc();

    // 4: scoreboard
    pend_set = 1; pend_addr = 9; setrd(0, 9);
    cyc();
    idle();
    #1 chk("t4_busy", 32'(ifa.rbusy[0]), 32'd1);
    cyc();
    we0 = 1; waddr0 = 9; wdata0 = 32'h42;
    #1 chk("t4_clr_busy", 32'(ifa.rbusy[0]), 32'd0);
    chk("t4_clr_data", ifa.rdata[31:0], 32'h42);
    cyc();
    pend_set = 1; pend_addr = 9; we0 = 1; waddr0 = 9; wdata0 = 32'h43;
    cyc();
    idle();
    #1 chk("t4_set_wins", 32'(ifa.rbusy[0]), 32'd1);
    cyc();

    // 5: out-of-range on the 16-register instance, three independent ports
    we0 = 1; waddr0 = 20; wdata0 = 32'hBEEF; setrd(0, 20);
    cyc();
    idle();
    #1 chk("t5_oor_b", ifb.rdata[31:0], 32'h0);
    chk("t5_inr_a", ifa.rdata[31:0], 32'hBEEF);
    cyc();
    we0 = 1; waddr0 = 1; wdata0 = 32'h11; we1 = 1; waddr1 = 2; wdata1 = 32'h22;
    cyc();
    we0 = 1; waddr0 = 3; wdata0 = 32'h33; we1 = 0;
    cyc();
    idle(); setrd(0, 1); setrd(1, 2); setrd(2, 3);
    #1 chk("t5_p0", ifb.rdata[31:0], 32'h11);
    chk("t5_p1", ifb.rdata[63:32], 32'h22);
    chk("t5_p2", ifb.rdata[95:64], 32'h33);
    cyc();

    // 6: reset mid-run clears contents and scoreboard
    pend_set = 1; pend_addr = 4; we0 = 1; waddr0 = 3; wdata0 = 32'h77;
    cyc();
    idle(); rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 32; i++) cyc();
    setrd(0, 3); setrd(1, 4);
    #1 chk("t6_data", ifa.rdata[31:0], 32'h0);
    chk("t6_busy", 32'(ifa.rbusy[1]), 32'd0);
    cyc();

    // random traffic, addresses often clustered to provoke hazards/bypass
    for (int t = 0; t < 800; t++) begin
      rst       = ($urandom_range(0, 249) == 0);
      we0       = $urandom_range(0, 1) != 0;
      we1       = $urandom_range(0, 2) == 0;
      pend_set  = $urandom_range(0, 2) == 0;
      waddr0    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      waddr1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      pend_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata0    = $urandom;
      wdata1    = $urandom;
      re        = 3'($urandom);
      for (int k = 0; k < 3; k++)
        raddr[k*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
